// File: rtl/hazard_ctrl.sv
// D-stage instruction classifier and hazard controller for the five-stage MIPS core:
// tracks E/M/W destination records, drives stall and forwarding selects, owns the mult/div busy counter.
module hazard_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10,
  parameter bit          MD_EN       = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr_D,
  output logic        stall,
  output logic        md_start,
  output logic        md_busy,
  output logic [1:0]  fwd_rs_D,
  output logic [1:0]  fwd_rt_D,
  output logic [1:0]  fwd_rs_E,
  output logic [1:0]  fwd_rt_E,
  output logic        fwd_rt_M
);

  localparam int unsigned CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1a;
  localparam logic [5:0] FN_DIVU  = 6'h1b;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2a;
  localparam logic [5:0] FN_SLTU  = 6'h2b;

  logic [5:0] w_op;
  logic [5:0] w_funct;
  logic [4:0] w_rs_f;
  logic [4:0] w_rt_f;
  logic [4:0] w_rd_f;
  logic       w_shamt_zero;

  assign w_op         = instr_D[31:26];
  assign w_rs_f       = instr_D[25:21];
  assign w_rt_f       = instr_D[20:16];
  assign w_rd_f       = instr_D[15:11];
  assign w_funct      = instr_D[5:0];
  assign w_shamt_zero = (instr_D[10:6] == 5'd0);

  // Decoded D-stage view; unused source fields are forced to $0 so they never match.
  logic [4:0] w_d_rs;
  logic [4:0] w_d_rt;
  logic [1:0] w_tuse_rs;
  logic [1:0] w_tuse_rt;
  logic [4:0] w_d_dst;
  logic [1:0] w_d_tnew;
  logic       w_d_md;
  logic       w_d_div;
  logic       w_d_mdcls;

  always_comb begin
    w_d_rs    = 5'd0;
    w_d_rt    = 5'd0;
    w_tuse_rs = 2'd0;
    w_tuse_rt = 2'd0;
    w_d_dst   = 5'd0;
    w_d_tnew  = 2'd0;
    w_d_md    = 1'b0;
    w_d_div   = 1'b0;
    w_d_mdcls = 1'b0;
    case (w_op)
      OP_RTYPE: begin
        if (w_shamt_zero) begin
          case (w_funct)
            FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, FN_SLTU: begin
              w_d_rs    = w_rs_f;
              w_tuse_rs = 2'd1;
              w_d_rt    = w_rt_f;
              w_tuse_rt = 2'd1;
              w_d_dst   = w_rd_f;
              w_d_tnew  = 2'd1;
            end
            FN_JR: begin
              w_d_rs    = w_rs_f;
              w_tuse_rs = 2'd0;
            end
            FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
              if (MD_EN) begin
                w_d_rs    = w_rs_f;
                w_tuse_rs = 2'd1;
                w_d_rt    = w_rt_f;
                w_tuse_rt = 2'd1;
                w_d_md    = 1'b1;
                w_d_div   = w_funct[1];
                w_d_mdcls = 1'b1;
              end
            end
            FN_MFHI, FN_MFLO: begin
              if (MD_EN) begin
                w_d_dst   = w_rd_f;
                w_d_tnew  = 2'd1;
                w_d_mdcls = 1'b1;
              end
            end
            FN_MTHI, FN_MTLO: begin
              if (MD_EN) begin
                w_d_rs    = w_rs_f;
                w_tuse_rs = 2'd1;
                w_d_mdcls = 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
      OP_ORI, OP_ANDI, OP_ADDI: begin
        w_d_rs    = w_rs_f;
        w_tuse_rs = 2'd1;
        w_d_dst   = w_rt_f;
        w_d_tnew  = 2'd1;
      end
      OP_LUI: begin
        w_d_dst  = w_rt_f;
        w_d_tnew = 2'd1;
      end
      OP_LW, OP_LH, OP_LB: begin
        w_d_rs    = w_rs_f;
        w_tuse_rs = 2'd1;
        w_d_dst   = w_rt_f;
        w_d_tnew  = 2'd2;
      end
      OP_SW, OP_SH, OP_SB: begin
        w_d_rs    = w_rs_f;
        w_tuse_rs = 2'd1;
        w_d_rt    = w_rt_f;
        w_tuse_rt = 2'd2;
      end
      OP_BEQ, OP_BNE: begin
        w_d_rs    = w_rs_f;
        w_tuse_rs = 2'd0;
        w_d_rt    = w_rt_f;
        w_tuse_rt = 2'd0;
      end
      OP_JAL: begin
        w_d_dst  = 5'd31;
        w_d_tnew = 2'd0;
      end
      default: ;
    endcase
  end

  // In-flight records for E, M and W.
  logic [4:0]       r_e_dst;
  logic [1:0]       r_e_tnew;
  logic             r_e_md;
  logic             r_e_div;
  logic [4:0]       r_e_rs;
  logic [4:0]       r_e_rt;
  logic [4:0]       r_m_dst;
  logic [1:0]       r_m_tnew;
  logic [4:0]       r_m_rt;
  logic [4:0]       r_w_dst;
  logic [1:0]       r_w_tnew;
  logic [CNT_W-1:0] r_md_cnt;

  logic w_md_start;
  logic w_md_busy;
  logic w_hz_rs;
  logic w_hz_rt;
  logic w_hz_md;
  logic w_stall;

  assign w_md_start = MD_EN && r_e_md;
  assign w_md_busy  = MD_EN && (r_md_cnt != CNT_W'(0));

  // A source stalls when the producer in E or M cannot deliver before the consumer needs it.
  always_comb begin
    w_hz_rs = 1'b0;
    w_hz_rt = 1'b0;
    if (w_d_rs != 5'd0) begin
      w_hz_rs = ((w_d_rs == r_e_dst) && (r_e_tnew > w_tuse_rs)) ||
                ((w_d_rs == r_m_dst) && (r_m_tnew > w_tuse_rs));
    end
    if (w_d_rt != 5'd0) begin
      w_hz_rt = ((w_d_rt == r_e_dst) && (r_e_tnew > w_tuse_rt)) ||
                ((w_d_rt == r_m_dst) && (r_m_tnew > w_tuse_rt));
    end
    w_hz_md = w_d_mdcls && (w_md_busy || w_md_start);
    w_stall = w_hz_rs || w_hz_rt || w_hz_md;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_e_dst  <= 5'd0;
      r_e_tnew <= 2'd0;
      r_e_md   <= 1'b0;
      r_e_div  <= 1'b0;
      r_e_rs   <= 5'd0;
      r_e_rt   <= 5'd0;
      r_m_dst  <= 5'd0;
      r_m_tnew <= 2'd0;
      r_m_rt   <= 5'd0;
      r_w_dst  <= 5'd0;
      r_w_tnew <= 2'd0;
    end else begin
      r_w_dst  <= r_m_dst;
      r_w_tnew <= (r_m_tnew != 2'd0) ? r_m_tnew - 2'd1 : 2'd0;
      r_m_dst  <= r_e_dst;
      r_m_tnew <= (r_e_tnew != 2'd0) ? r_e_tnew - 2'd1 : 2'd0;
      r_m_rt   <= r_e_rt;
      if (w_stall) begin
        r_e_dst  <= 5'd0;
        r_e_tnew <= 2'd0;
        r_e_md   <= 1'b0;
        r_e_div  <= 1'b0;
        r_e_rs   <= 5'd0;
        r_e_rt   <= 5'd0;
      end else begin
        r_e_dst  <= w_d_dst;
        r_e_tnew <= w_d_tnew;
        r_e_md   <= w_d_md;
        r_e_div  <= w_d_div;
        r_e_rs   <= w_d_rs;
        r_e_rt   <= w_d_rt;
      end
    end
  end

  // Mult/div busy window; the start cycle itself is covered by md_start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_md_cnt <= CNT_W'(0);
    end else if (w_md_start) begin
      r_md_cnt <= r_e_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    end else if (r_md_cnt != CNT_W'(0)) begin
      r_md_cnt <= r_md_cnt - CNT_W'(1);
    end
  end

  // Forwarding: nearest ready producer wins; $0 never matches.
  always_comb begin
    fwd_rs_D = 2'd0;
    fwd_rt_D = 2'd0;
    fwd_rs_E = 2'd0;
    fwd_rt_E = 2'd0;
    fwd_rt_M = 1'b0;
    if (w_d_rs != 5'd0) begin
      if ((w_d_rs == r_e_dst) && (r_e_tnew == 2'd0))      fwd_rs_D = 2'd1;
      else if ((w_d_rs == r_m_dst) && (r_m_tnew == 2'd0)) fwd_rs_D = 2'd2;
    end
    if (w_d_rt != 5'd0) begin
      if ((w_d_rt == r_e_dst) && (r_e_tnew == 2'd0))      fwd_rt_D = 2'd1;
      else if ((w_d_rt == r_m_dst) && (r_m_tnew == 2'd0)) fwd_rt_D = 2'd2;
    end
    if (r_e_rs != 5'd0) begin
      if ((r_e_rs == r_m_dst) && (r_m_tnew == 2'd0))      fwd_rs_E = 2'd1;
      else if ((r_e_rs == r_w_dst) && (r_w_tnew == 2'd0)) fwd_rs_E = 2'd2;
    end
    if (r_e_rt != 5'd0) begin
      if ((r_e_rt == r_m_dst) && (r_m_tnew == 2'd0))      fwd_rt_E = 2'd1;
      else if ((r_e_rt == r_w_dst) && (r_w_tnew == 2'd0)) fwd_rt_E = 2'd2;
    end
    if ((r_m_rt != 5'd0) && (r_m_rt == r_w_dst) && (r_w_tnew == 2'd0)) fwd_rt_M = 1'b1;
  end

  assign stall    = w_stall;
  assign md_start = w_md_start;
  assign md_busy  = w_md_busy;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: hand-computed stall/forwarding/mult-div expectations.
module tb_hazard_ctrl;

  logic        clk;
  logic        rst_n;
  logic [31:0] instr_D;
  logic        stall;
  logic        md_start;
  logic        md_busy;
  logic [1:0]  fwd_rs_D;
  logic [1:0]  fwd_rt_D;
  logic [1:0]  fwd_rs_E;
  logic [1:0]  fwd_rt_E;
  logic        fwd_rt_M;

  int n_cmp;
  int n_bad;

  localparam logic [31:0] NOP = 32'h0000_0000;

  hazard_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .instr_D  (instr_D),
    .stall    (stall),
    .md_start (md_start),
    .md_busy  (md_busy),
    .fwd_rs_D (fwd_rs_D),
    .fwd_rt_D (fwd_rt_D),
    .fwd_rs_E (fwd_rs_E),
    .fwd_rt_E (fwd_rt_E),
    .fwd_rt_M (fwd_rt_M)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input int fn);
    enc_r = {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
  endfunction

  function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input int imm);
    enc_i = {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a new D instruction just after an edge and let combinational outputs settle.
  task automatic put(input logic [31:0] ins);
    instr_D = ins;
    #1;
  endtask

  task automatic flush();
    put(NOP);
    repeat (4) tick();
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_stall"},    int'(stall),    0);
    chk({tag, "_mdstart"},  int'(md_start), 0);
    chk({tag, "_mdbusy"},   int'(md_busy),  0);
    chk({tag, "_fwdrsD"},   int'(fwd_rs_D), 0);
    chk({tag, "_fwdrtD"},   int'(fwd_rt_D), 0);
    chk({tag, "_fwdrsE"},   int'(fwd_rs_E), 0);
    chk({tag, "_fwdrtE"},   int'(fwd_rt_E), 0);
    chk({tag, "_fwdrtM"},   int'(fwd_rt_M), 0);
  endtask

  initial begin
    int ncyc;
    n_cmp   = 0;
    n_bad   = 0;
    rst_n   = 1'b0;
    instr_D = NOP;
    repeat (2) @(posedge clk);
    #2;
    chk_idle("rst");
    rst_n = 1'b1;
    tick();
    chk_idle("post_rst");

    // lw $8 then add $9,$8,$8: one stall, then W->E forwarding on both operands
    put(enc_i(8'h23, 0, 8, 0));
    chk("lw_no_stall", int'(stall), 0);
    tick();
    put(enc_r(8, 8, 9, 8'h20));
    chk("lwadd_stall1", int'(stall), 1);
    tick();
    chk("lwadd_stall2", int'(stall), 0);
    chk("lwadd_fwdrsD", int'(fwd_rs_D), 0);
    tick();
    put(NOP);
    chk("lwadd_fwdrsE", int'(fwd_rs_E), 2);
    chk("lwadd_fwdrtE", int'(fwd_rt_E), 2);
    flush();

    // lw $8 then beq $8,$0: two stalls, then register-file path
    put(enc_i(8'h23, 0, 8, 0));
    tick();
    put(enc_i(8'h04, 8, 0, 4));
    chk("lwbeq_stall_a", int'(stall), 1);
    tick();
    chk("lwbeq_stall_b", int'(stall), 1);
    tick();
    chk("lwbeq_stall_c", int'(stall), 0);
    chk("lwbeq_fwdrsD", int'(fwd_rs_D), 0);
    flush();

    // ori $4 then beq $4,$0: one stall, then M->D forward
    put(enc_i(8'h0d, 0, 4, 1));
    tick();
    put(enc_i(8'h04, 4, 0, 4));
    chk("oribeq_stall", int'(stall), 1);
    tick();
    chk("oribeq_nostall", int'(stall), 0);
    chk("oribeq_fwdrsD", int'(fwd_rs_D), 2);
    flush();

    // ori $5 then sw $5,0($6): no stall, M->E forward on store data
    put(enc_i(8'h0d, 0, 5, 1));
    tick();
    put(enc_i(8'h2b, 6, 5, 0));
    chk("orisw_stall", int'(stall), 0);
    tick();
    put(NOP);
    chk("orisw_fwdrtE", int'(fwd_rt_E), 1);
    chk("orisw_fwdrsE", int'(fwd_rs_E), 0);
    chk("orisw_fwdrtM", int'(fwd_rt_M), 0);
    flush();

    // lw $7 then sw $7,4($0): store data picked up from W in M
    put(enc_i(8'h23, 0, 7, 0));
    tick();
    put(enc_i(8'h2b, 0, 7, 4));
    chk("lwsw_stall", int'(stall), 0);
    tick();
    put(NOP);
    chk("lwsw_fwdrtE", int'(fwd_rt_E), 0);
    tick();
    chk("lwsw_fwdrtM", int'(fwd_rt_M), 1);
    flush();

    // jal then jr $31: E->D forward of the link value, then M->E
    put({6'h03, 26'h0000010});
    tick();
    put(enc_r(31, 0, 0, 8'h08));
    chk("jaljr_stall", int'(stall), 0);
    chk("jaljr_fwdrsD", int'(fwd_rs_D), 1);
    tick();
    put(NOP);
    chk("jaljr_fwdrsE", int'(fwd_rs_E), 1);
    flush();

    // lw $0 then add $2,$0,$0: $0 never stalls nor forwards
    put(enc_i(8'h23, 0, 0, 0));
    tick();
    put(enc_r(0, 0, 2, 8'h20));
    chk("zero_stall", int'(stall), 0);
    chk("zero_fwdrsD", int'(fwd_rs_D), 0);
    flush();

    // div $1,$2 then mflo $3: 11 stall cycles (start + 10 busy)
    put(enc_r(1, 2, 0, 8'h1a));
    chk("div_stall", int'(stall), 0);
    chk("div_mdstart_d", int'(md_start), 0);
    tick();
    put(enc_r(0, 0, 3, 8'h12));
    chk("div_mdstart", int'(md_start), 1);
    chk("div_busy0", int'(md_busy), 0);
    chk("mflo_stall0", int'(stall), 1);
    ncyc = 1;
    tick();
    chk("div_mdstart_off", int'(md_start), 0);
    chk("div_busy1", int'(md_busy), 1);
    while (stall && ncyc < 40) begin
      ncyc++;
      tick();
    end
    chk("mflo_stall_cycles", ncyc, 11);
    chk("div_busy_end", int'(md_busy), 0);
    flush();

    // Reset mid-division clears busy immediately
    put(enc_r(3, 4, 0, 8'h1b));
    tick();
    put(NOP);
    chk("divu_mdstart", int'(md_start), 1);
    tick();
    tick();
    chk("divu_busy", int'(md_busy), 1);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", int'(md_busy), 0);
    chk("arst_mdstart", int'(md_start), 0);
    #2;
    rst_n = 1'b1;
    tick();
    chk_idle("rel");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
